// File: rtl/path_delay_meter_if.sv
// Control/result bundle between a path_delay_meter and whatever drives it.
// The launch/response pins stay outside because they go to the path under test.
interface path_delay_meter_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             clear_max;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] delay_cnt;
    logic [CNT_W-1:0] delay_max;

    // The controller side issues requests and reads back results.
    modport master (
        output start,
        output clear_max,
        input  busy,
        input  done,
        input  timeout,
        input  delay_cnt,
        input  delay_max
    );

    // The meter side accepts requests and publishes results.
    modport slave (
        input  start,
        input  clear_max,
        output busy,
        output done,
        output timeout,
        output delay_cnt,
        output delay_max
    );
endinterface

// File: rtl/path_delay_meter.sv
// Round-trip delay meter: toggles stim_out, then counts clk cycles until the
// synchronised response differs from its level at launch. Results include the
// two-cycle synchronizer latency, so a zero-delay loopback reads 2.
module path_delay_meter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    path_delay_meter_if.slave mif,
    input  logic              resp_in,
    output logic              stim_out
);
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Last count value before a measurement is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             resp_meta;
    logic             resp_s;
    logic             resp_ref;
    logic [CNT_W-1:0] cnt;
    logic             detect;

    assign detect = (resp_s != resp_ref);

    // Bring the asynchronous response pin into the clk domain; nothing else looks at resp_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_meta <= 1'b0;
            resp_s    <= 1'b0;
        end else begin
            resp_meta <= resp_in;
            resp_s    <= resp_meta;
        end
    end

    // Launch on start, then wait for the response edge or give up after TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stim_out      <= 1'b0;
            resp_ref      <= 1'b0;
            cnt           <= '0;
            mif.busy      <= 1'b0;
            mif.done      <= 1'b0;
            mif.timeout   <= 1'b0;
            mif.delay_cnt <= '0;
        end else begin
            mif.done    <= 1'b0;
            mif.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (mif.start) begin
                        stim_out <= ~stim_out;
                        resp_ref <= resp_s;
                        cnt      <= '0;
                        mif.busy <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (detect) begin
                        mif.delay_cnt <= cnt;
                        mif.done      <= 1'b1;
                        mif.busy      <= 1'b0;
                        state         <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        mif.delay_cnt <= '1;
                        mif.timeout   <= 1'b1;
                        mif.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    mif.busy <= 1'b0;
                end
            endcase
        end
    end

    // Track the worst delay; folds in the fresh result while done is high, and a
    // clear in that same cycle restarts the history from that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mif.delay_max <= '0;
        end else if (mif.done) begin
            if (mif.clear_max) begin
                mif.delay_max <= mif.delay_cnt;
            end else if (mif.delay_cnt > mif.delay_max) begin
                mif.delay_max <= mif.delay_cnt;
            end
        end else if (mif.clear_max) begin
            mif.delay_max <= '0;
        end
    end
endmodule

// File: doc/path_delay_meter.md
PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of the delay counter and results.
REQ-002 SHALL provide parameter TIMEOUT, default 200, the number of WAIT cycles before a measurement is abandoned; legal range 3..2^CNT_W-2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request one measurement; sampled only in IDLE.
REQ-006 SHALL have port clear_max  input  1  clears delay_max.
REQ-007 SHALL have port resp_in  input  1  response pin from the path under test; asynchronous to clk.
REQ-008 SHALL have port stim_out  output  1  launch pin driving the path under test; registered.
REQ-009 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a measurement completes.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when a measurement is abandoned.
REQ-012 SHALL have port delay_cnt  output  CNT_W  last measured delay in clk cycles.
REQ-013 SHALL have port delay_max  output  CNT_W  largest delay_cnt since reset or clear_max.

Function
REQ-014 SHALL pass resp_in through a two-flop synchronizer; the second flop output is resp_s, and no logic SHALL use resp_in directly.
REQ-015 SHALL implement FSM states IDLE and WAIT only: IDLE->WAIT on start; WAIT->IDLE on detect or on timeout.
REQ-016 SHALL, at the IDLE edge where start=1, toggle stim_out, latch ref=resp_s, clear cnt to 0, and enter WAIT.
REQ-017 SHALL assert busy exactly while the state is WAIT.
REQ-018 SHALL, on each WAIT edge with resp_s != ref (detect), load delay_cnt<=cnt, pulse done for the following cycle, and return to IDLE.
REQ-019 SHALL, on each WAIT edge without detect and with cnt < TIMEOUT-1, increment cnt by 1.
REQ-020 SHALL, on the WAIT edge without detect and with cnt == TIMEOUT-1, load delay_cnt with all ones, pulse timeout, and return to IDLE without toggling stim_out.
REQ-021 SHALL report 2 for a zero-delay loopback (synchronizer latency), and 2+d when resp_in changes d full cycles after stim_out; the result is exact when resp_in meets setup to clk.
REQ-022 SHALL never assert done and timeout in the same cycle; detect wins if both conditions occur on the same edge.
REQ-023 SHALL ignore start while in WAIT, with no queuing.
REQ-024 SHALL ignore resp_in changes in IDLE; only the difference from ref at WAIT edges counts.
REQ-025 SHALL, on done, update delay_max<=max(delay_max, new delay_cnt).
REQ-026 SHALL NOT update delay_max on timeout.
REQ-027 SHALL, on clear_max alone, set delay_max<=0.
REQ-028 SHALL, when clear_max coincides with done, set delay_max<=new delay_cnt.
REQ-029 SHALL NOT wrap cnt; REQ-020 bounds it below 2^CNT_W-1.
REQ-030 SHALL allow back-to-back measurements: start on the cycle done is high (state IDLE) launches the next measurement with the opposite stim_out edge.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, stim_out=0, busy=0, done=0, timeout=0, delay_cnt=0, delay_max=0, cnt=0, both synchronizer flops=0, and ref=0.
REQ-032 SHALL, on reset asserted mid-WAIT, abandon the measurement with no done or timeout pulse and drive stim_out low within the same cycle.
REQ-033 SHALL begin normal operation at the first rising clk edge after rst_n deasserts.

Verification
REQ-034 Zero-delay loopback (resp_in=stim_out), pulse start -> stim_out 0->1, done pulses, delay_cnt=2, delay_max=2.
REQ-035 Loopback through a 5-cycle delay line, two back-to-back starts -> stim_out rises then falls; both results delay_cnt=7; delay_max=7.
REQ-036 resp_in held constant, TIMEOUT=200 -> timeout pulses 200 cycles after launch; delay_cnt=255; delay_max unchanged; done never asserts.
REQ-037 Delays 3, 9, 4 cycles (results 5, 11, 6), then clear_max asserted on the cycle done is high for a 2-cycle delay -> delay_max sequence 5, 11, 11, then 4.
REQ-038 rst_n pulsed low 10 cycles into WAIT -> stim_out=0 and busy=0 immediately, no done/timeout pulse; next start reports a correct delay.
REQ-039 start pulsed again while busy -> ignored: a single done pulse, and stim_out toggles exactly once.
